inst_fetch_queue: RTL and testbench

Fetch stage sitting directly downstream of the PC control unit and upstream of decode. Accepts one word-indexed PC per cycle when the PC unit asserts available, issues a single-outstanding read to instruction memory, and buffers returned {pc, instruction} pairs in a small FIFO drained by decode. On a branch redirect (pcChange) it flushes the FIFO and discards the in-flight response. It also back-pressures the PC unit when it has no room.

---
 rtl/inst_fetch_queue.sv | 185 ++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage between the PC unit and decode.
// Accepts one PC at a time and keeps a single read outstanding to
// instruction memory. Returned {pc, inst} pairs are buffered in a small
// FIFO that decode drains. A redirect flushes the FIFO and toggles an
// epoch bit, so the response that is still in flight gets discarded.
// Optional build macro: FETCH_BYPASS_EN. When it is defined, a response
// that arrives while the FIFO is empty and decode is ready goes straight
// to the dec_* outputs in the same cycle.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             pc_valid,
    input  logic [31:0]      pc,
    output logic             fetch_ready,
    input  logic             redirect,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             dec_valid,
    output logic [31:0]      dec_inst,
    output logic [31:0]      dec_pc,
    input  logic             dec_ready,
    output logic [PTR_W:0]   count
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    state_t             r_state, w_state_nxt;
    logic               r_epoch, r_req_epoch;
    logic [31:0]        r_req_pc;
    logic               r_imem_req;
    logic [31:0]        r_imem_addr;

    logic [31:0]        r_mem_inst [DEPTH];
    logic [31:0]        r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [PTR_W:0]     r_count, w_count_nxt;

    logic               r_dec_valid;
    logic [31:0]        r_dec_inst, r_dec_pc;
    logic [31:0]        w_head_inst, w_head_pc;

    logic               w_fetch_ready, w_accept, w_resp_ok;
    logic               w_push, w_pop, w_bypass;

    // Next-state and handshake decode. Accepting a PC reserves one FIFO
    // slot, so count < DEPTH here means the response always finds room.
    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_ready = 1'b0;
        w_accept      = 1'b0;
        w_resp_ok     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_fetch_ready = rst_n && !redirect && (r_count < CNT_FULL);
                w_accept      = pc_valid && w_fetch_ready;
                if (w_accept)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Stale-epoch responses, and responses that arrive together
                // with a redirect, still end the wait but are not kept.
                if (imem_rvalid) begin
                    w_resp_ok   = (r_req_epoch == r_epoch) && !redirect;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef FETCH_BYPASS_EN
    assign w_bypass    = w_resp_ok && (r_count == '0) && dec_ready;
    assign dec_valid   = r_dec_valid | w_bypass;
    assign dec_inst    = w_bypass ? imem_rdata : r_dec_inst;
    assign dec_pc      = w_bypass ? r_req_pc   : r_dec_pc;
`else
    assign w_bypass    = 1'b0;
    assign dec_valid   = r_dec_valid;
    assign dec_inst    = r_dec_inst;
    assign dec_pc      = r_dec_pc;
`endif

    assign w_push      = w_resp_ok && !w_bypass;
    assign w_pop       = r_dec_valid && dec_ready && !redirect;
    assign fetch_ready = w_fetch_ready;
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign count       = r_count;

    // Occupancy and read pointer after this edge. Redirect overrides push/pop.
    always_comb begin
        w_count_nxt  = r_count;
        w_rd_ptr_nxt = r_rd_ptr;
        if (redirect) begin
            w_count_nxt  = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_pop)
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                w_count_nxt = r_count + CNT_ONE;
            else if (!w_push && w_pop)
                w_count_nxt = r_count - CNT_ONE;
        end
    end

    // Head entry after this edge. If the write slot becomes the head, the
    // FIFO is empty after the pop, so the incoming response is the new head.
    always_comb begin
        w_head_inst = r_mem_inst[w_rd_ptr_nxt];
        w_head_pc   = r_mem_pc[w_rd_ptr_nxt];
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_inst = imem_rdata;
            w_head_pc   = r_req_pc;
        end
    end

    // FSM state, epoch and the single outstanding request slot.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_epoch     <= 1'b0;
            r_req_epoch <= 1'b0;
            r_req_pc    <= '0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_imem_req <= w_accept;
            if (redirect)
                r_epoch <= ~r_epoch;
            if (w_accept) begin
                r_imem_addr <= pc;
                r_req_pc    <= pc;
                r_req_epoch <= r_epoch;
            end
        end
    end

    // FIFO pointers, occupancy and the registered head presented to decode.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dec_valid <= 1'b0;
            r_dec_inst  <= '0;
            r_dec_pc    <= '0;
        end else if (redirect) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dec_valid <= 1'b0;
            r_dec_inst  <= '0;
            r_dec_pc    <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_dec_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_dec_inst <= w_head_inst;
                r_dec_pc   <= w_head_pc;
            end
        end
    end

    // Entry storage is not reset; only occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue. A table of per-cycle vectors covers the
// basic fetch flow. Hand-written sequences then cover full/back-pressure,
// redirect, simultaneous push/pop across pointer wrap, and reset mid-wait.
module tb_inst_fetch_queue;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        fetch_ready;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_inst, dec_pc;
    logic        dec_ready = 1'b0;
    logic [2:0]  count;

    // Memory source: table-driven, or a latency model that answers imem_req.
    logic        mem_en = 1'b0;
    int          mem_lat = 1;
    logic        tbl_rvalid = 1'b0;
    logic [31:0] tbl_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    assign imem_rvalid = mem_en ? mem_rvalid : tbl_rvalid;
    assign imem_rdata  = mem_en ? mem_rdata  : tbl_rdata;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc),
        .fetch_ready(fetch_ready), .redirect(redirect), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .count(count)
    );

    always #5 clock = ~clock;

    // Instruction memory model: data = 0x100 + address, mem_lat cycles after req.
    initial begin
        int cd;
        logic [31:0] paddr;
        cd = 0;
        paddr = '0;
        forever begin
            @(negedge clock);
            mem_rvalid = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'h100 + paddr;
                end
            end
            if (imem_req) begin
                cd    = mem_lat;
                paddr = imem_addr;
            end
        end
    end

    typedef struct {
        int pv, pc, rv, rd, dr;
        int fr, rq, ad, dv, dpc, dinst, cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // PC unit: present p until fetch_ready takes it (bounded).
    task automatic issue(input int p);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            pc_valid = 1'b1;
            pc = 32'(p);
            #1;
            if (fetch_ready) ok = 1'b1;
            @(negedge clock);
        end
        pc_valid = 1'b0;
        chk($sformatf("issue_pc%0d_accepted", p), 32'(ok), 32'd1);
    endtask

    task automatic wait_cnt(input int c);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (int'(count) == c) break;
            @(negedge clock);
        end
        chk($sformatf("wait_count_%0d", c), 32'(count), 32'(c));
    endtask

    // Pop n entries and compare against the scoreboard.
    task automatic drain(input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            dec_ready = 1'b1;
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("drain_dec_valid", 32'(dec_valid), 32'd1);
            chk("drain_dec_pc", dec_pc, 32'(e));
            chk("drain_dec_inst", dec_inst, 32'h100 + 32'(e));
            @(negedge clock);
        end
        dec_ready = 1'b0;
    endtask

    initial begin
        int pc_cur, nreq, maxc;
        bit acc;

        //            pv pc rv rd      dr  fr rq ad dv dpc dinst   cnt
        tbl[0]  = '{1, 0, 0, 0,      1,  1, 0, 0, 0, 0, 0,      0};
        tbl[1]  = '{1, 1, 0, 0,      1,  0, 1, 0, 0, 0, 0,      0};
        tbl[2]  = '{1, 1, 1, 'h100,  1,  0, 0, 0, 0, 0, 0,      0};
        tbl[3]  = '{1, 1, 0, 0,      1,  1, 0, 0, 1, 0, 'h100,  1};
        tbl[4]  = '{1, 2, 0, 0,      1,  0, 1, 1, 0, 0, 0,      0};
        tbl[5]  = '{1, 2, 1, 'h101,  1,  0, 0, 1, 0, 0, 0,      0};
        tbl[6]  = '{1, 2, 0, 0,      1,  1, 0, 1, 1, 1, 'h101,  1};
        tbl[7]  = '{0, 0, 0, 0,      1,  0, 1, 2, 0, 0, 0,      0};
        tbl[8]  = '{0, 0, 1, 'h102,  1,  0, 0, 2, 0, 0, 0,      0};
        tbl[9]  = '{0, 0, 0, 0,      1,  1, 0, 2, 1, 2, 'h102,  1};
        tbl[10] = '{0, 0, 0, 0,      1,  1, 0, 2, 0, 0, 0,      0};
        tbl[11] = '{0, 0, 1, 'hbad,  1,  1, 0, 2, 0, 0, 0,      0};
        tbl[12] = '{0, 0, 0, 0,      1,  1, 0, 2, 0, 0, 0,      0};

        // Reset state
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_inst", dec_inst, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;

        // Basic fetch flow, 1-cycle memory, decode always ready
        for (int i = 0; i < 13; i++) begin
            pc_valid   = (tbl[i].pv != 0);
            pc         = 32'(tbl[i].pc);
            tbl_rvalid = (tbl[i].rv != 0);
            tbl_rdata  = 32'(tbl[i].rd);
            dec_ready  = (tbl[i].dr != 0);
            #1;
            chk($sformatf("row%0d_fetch_ready", i), 32'(fetch_ready), 32'(tbl[i].fr));
            chk($sformatf("row%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].rq));
            chk($sformatf("row%0d_imem_addr", i), imem_addr, 32'(tbl[i].ad));
            chk($sformatf("row%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].dv));
            chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            if (tbl[i].dv != 0) begin
                chk($sformatf("row%0d_dec_pc", i), dec_pc, 32'(tbl[i].dpc));
                chk($sformatf("row%0d_dec_inst", i), dec_inst, 32'(tbl[i].dinst));
            end
            @(negedge clock);
        end
        pc_valid = 1'b0;
        tbl_rvalid = 1'b0;
        dec_ready = 1'b0;

        // Fill: stream pc 0..7 with decode stalled; only 0..3 fit
        mem_en = 1'b1;
        mem_lat = 1;
        pc_cur = 0;
        nreq = 0;
        maxc = 0;
        for (int k = 0; k < 30; k++) begin
            pc_valid = 1'b1;
            pc = 32'(pc_cur);
            #1;
            acc = fetch_ready;
            if (imem_req) nreq++;
            if (int'(count) > maxc) maxc = int'(count);
            @(negedge clock);
            if (acc) begin
                exp_q.push_back(pc_cur);
                pc_cur++;
            end
        end
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_max_count", 32'(maxc), 32'd4);
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("full_held_pc", 32'(pc_cur), 32'd4);
        chk("full_num_req", 32'(nreq), 32'd4);
        chk("full_imem_req_idle", 32'(imem_req), 32'd0);

        // One pop from full frees a slot; next accept is pc 4
        @(negedge clock);
        dec_ready = 1'b1;
        pc_valid = 1'b1;
        pc = 32'd4;
        #1;
        chk("pop1_fetch_ready_before", 32'(fetch_ready), 32'd0);
        chk("pop1_head_pc", dec_pc, 32'(exp_q[0]));
        chk("pop1_head_inst", dec_inst, 32'h100);
        void'(exp_q.pop_front());
        @(negedge clock);
        dec_ready = 1'b0;
        #1;
        chk("pop1_count", 32'(count), 32'd3);
        chk("pop1_fetch_ready_after", 32'(fetch_ready), 32'd1);
        chk("pop1_new_head", dec_pc, 32'd1);
        issue(4);
        exp_q.push_back(4);
        wait_cnt(4);
        @(negedge clock);
        drain(4);
        #1;
        chk("drained_count", 32'(count), 32'd0);

        // Redirect during WAIT with 2 entries queued and pc 5 in flight
        @(negedge clock);
        issue(10);
        issue(11);
        wait_cnt(2);
        @(negedge clock);
        mem_lat = 3;
        issue(5);
        #1;
        chk("redir_pre_count", 32'(count), 32'd2);
        chk("redir_pre_req", 32'(imem_req), 32'd1);
        chk("redir_pre_addr", imem_addr, 32'd5);
        @(negedge clock);
        redirect = 1'b1;
        pc_valid = 1'b1;
        pc = 32'd99;
        #1;
        chk("redir_fetch_ready", 32'(fetch_ready), 32'd0);
        @(negedge clock);
        redirect = 1'b0;
        pc_valid = 1'b0;
        #1;
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_dec_valid", 32'(dec_valid), 32'd0);
        chk("redir_no_req", 32'(imem_req), 32'd0);
        maxc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1;
            if (int'(count) > maxc) maxc = int'(count);
            if (dec_valid) maxc = maxc + 8;
        end
        chk("redir_resp_dropped", 32'(maxc), 32'd0);
        mem_lat = 1;
        @(negedge clock);
        issue(20);
        exp_q.push_back(20);
        wait_cnt(1);
        @(negedge clock);
        drain(1);

        // Push and pop on the same edge at count 2, across pointer wrap
        issue(30);
        exp_q.push_back(30);
        issue(31);
        exp_q.push_back(31);
        wait_cnt(2);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            issue(40 + i);
            exp_q.push_back(40 + i);
            @(negedge clock);
            dec_ready = 1'b1;
            #1;
            chk($sformatf("pp%0d_count_before", i), 32'(count), 32'd2);
            chk($sformatf("pp%0d_head_pc", i), dec_pc, 32'(exp_q.pop_front()));
            @(negedge clock);
            dec_ready = 1'b0;
            #1;
            chk($sformatf("pp%0d_count_after", i), 32'(count), 32'd2);
            @(negedge clock);
        end
        drain(2);
        #1;
        chk("pp_final_count", 32'(count), 32'd0);

        // Reset mid-WAIT, then a late response after release
        @(negedge clock);
        mem_en = 1'b0;
        issue(50);
        rst_n = 1'b0;
        #1;
        chk("rstw_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rstw_imem_req", 32'(imem_req), 32'd0);
        chk("rstw_imem_addr", imem_addr, 32'd0);
        chk("rstw_count", 32'(count), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        tbl_rvalid = 1'b1;
        tbl_rdata = 32'hdead;
        #1;
        chk("rstw_idle_ready", 32'(fetch_ready), 32'd1);
        @(negedge clock);
        tbl_rvalid = 1'b0;
        #1;
        chk("rstw_late_count", 32'(count), 32'd0);
        chk("rstw_late_dec_valid", 32'(dec_valid), 32'd0);
        @(negedge clock);
        #1;
        chk("rstw_late_count2", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
